// File: rtl/chess_timer.sv
// Two-player chess clock: shared one-second prescaler, per-player MM:SS countdown,
// sticky flags on expiry, and a Fischer increment credited to the player who hands over.
module chess_timer #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int INIT_MIN      = 5,
    parameter int INIT_SEC      = 0,
    parameter int INC_SEC       = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       time_a,
    input  logic       time_b,
    input  logic       clr,
    output logic [6:0] a_min,
    output logic [5:0] a_sec,
    output logic [6:0] b_min,
    output logic [5:0] b_sec,
    output logic       flag_a,
    output logic       flag_b,
    output logic       game_over
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

    typedef struct packed {
        logic [6:0] m;
        logic [5:0] s;
    } mmss_t;

    localparam mmss_t INIT_T = '{m: 7'(INIT_MIN), s: 6'(INIT_SEC)};

    mmss_t         a_q, a_d, b_q, b_d;
    logic          fa_q, fa_d, fb_q, fb_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          prev_a_q, prev_a_d, prev_b_q, prev_b_d;
    logic          one_hot, tick, ho_ab, ho_ba;

    function automatic mmss_t dec_f(input mmss_t t);
        mmss_t r;
        r = t;
        if (t.s != 6'd0) begin
            r.s = t.s - 6'd1;
        end else if (t.m != 7'd0) begin
            r.s = 6'd59;
            r.m = t.m - 7'd1;
        end
        return r;
    endfunction

    // Bonus add with seconds carry; anything past 99:59 pins there.
    function automatic mmss_t inc_f(input mmss_t t);
        mmss_t      r;
        logic [6:0] s_sum;
        logic [7:0] m_sum;
        s_sum = {1'b0, t.s} + 7'(INC_SEC);
        m_sum = {1'b0, t.m};
        if (s_sum >= 7'd60) begin
            s_sum = s_sum - 7'd60;
            m_sum = m_sum + 8'd1;
        end
        if (m_sum > 8'd99) begin
            r.m = 7'd99;
            r.s = 6'd59;
        end else begin
            r.m = m_sum[6:0];
            r.s = s_sum[5:0];
        end
        return r;
    endfunction

    assign game_over = fa_q | fb_q;
    assign one_hot   = time_a ^ time_b;
    assign tick      = one_hot && !game_over && (pre_q == PRE_MAX);
    assign ho_ab     = prev_a_q && !time_a && time_b && !game_over;
    assign ho_ba     = prev_b_q && !time_b && time_a && !game_over;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        fa_d     = fa_q;
        fb_d     = fb_q;
        pre_d    = pre_q;
        prev_a_d = time_a;
        prev_b_d = time_b;
        if (clr) begin
            a_d      = INIT_T;
            b_d      = INIT_T;
            fa_d     = 1'b0;
            fb_d     = 1'b0;
            pre_d    = '0;
            prev_a_d = 1'b0;
            prev_b_d = 1'b0;
        end else if (!game_over) begin
            // The prescaler is shared, so a partial second carries across handovers.
            if (one_hot) pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick && time_a) begin
                a_d = dec_f(a_q);
                if (a_d == '0) fa_d = 1'b1;
            end
            if (tick && time_b) begin
                b_d = dec_f(b_q);
                if (b_d == '0) fb_d = 1'b1;
            end
            if (ho_ab) a_d = inc_f(a_q);
            if (ho_ba) b_d = inc_f(b_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= INIT_T;
            b_q      <= INIT_T;
            fa_q     <= 1'b0;
            fb_q     <= 1'b0;
            pre_q    <= '0;
            prev_a_q <= 1'b0;
            prev_b_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            pre_q    <= pre_d;
            prev_a_q <= prev_a_d;
            prev_b_q <= prev_b_d;
        end
    end

    assign a_min  = a_q.m;
    assign a_sec  = a_q.s;
    assign b_min  = b_q.m;
    assign b_sec  = b_q.s;
    assign flag_a = fa_q;
    assign flag_b = fb_q;

endmodule
